nibble_entry_ctrl: RTL and testbench
====================================

NIBBLE_ENTRY_CTRL -- requirements
Module: nibble_entry_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, write-word width in bits; legal values are multiples of 4, minimum 4.
REQ-002 SHALL have parameter DEPTH, default 32, number of addressable words; minimum 2.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), write-address width.
REQ-004 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port addr_incr, input, 1, asynchronous button; each rise requests address +1.
REQ-007 SHALL have port addr_decr, input, 1, asynchronous button; each rise requests address -1.
REQ-008 SHALL have port e, input, 1, asynchronous nibble-enter strobe; each rise captures data.
REQ-009 SHALL have port data, input, 4, nibble value sampled on a detected e rise.
REQ-010 SHALL have port wadd, output, ADDR_W, current write address.
REQ-011 SHALL have port din, output, DATA_W, assembled write word.
REQ-012 SHALL have port w, output, 1, write-enable pulse.
REQ-013 SHALL have port nibble_idx, output, $clog2(DATA_W/4) (min 1), nibble count already entered for the current word.
REQ-014 SHALL have port pending, output, 1, high while a button request is queued.

Function
REQ-015 SHALL pass addr_incr, addr_decr and e through a 2-flop synchroniser plus rising-edge detector each; a detected event is a 1-cycle pulse 3 clk edges after the input rises.
REQ-016 SHALL implement states INIT, COLLECT, WRITE, ADVANCE; INIT -> COLLECT unconditionally after 1 cycle, clearing wadd, din and nibble_idx.
REQ-017 In COLLECT, an e event SHALL load data into din, most-significant nibble first (nibble n into bits DATA_W-1-4n:DATA_W-4-4n), and increment nibble_idx.
REQ-018 When the last nibble (index DATA_W/4-1) is captured, SHALL go to WRITE next cycle with nibble_idx cleared.
REQ-019 SHALL assert w for exactly the single WRITE cycle, with wadd and din stable and valid throughout; WRITE -> ADVANCE.
REQ-020 ADVANCE SHALL apply the post-write address step (REQ-028) and go to COLLECT; a write therefore occupies 2 cycles after the final e event.
REQ-021 In COLLECT, an incr event SHALL set wadd to wadd+1, wrapping DEPTH-1 -> 0; decr SHALL set wadd-1, wrapping 0 -> DEPTH-1; either clears nibble_idx, discarding partially entered nibbles (din bits retain their values).
REQ-022 Simultaneous incr and decr events SHALL cancel: no address change and no pending request.
REQ-023 A button event and an e event in the same COLLECT cycle SHALL apply the button; the e event is dropped.
REQ-024 Button events in WRITE or ADVANCE SHALL be queued (one entry, pending=1, latest direction wins) and applied in the first COLLECT cycle after any ADVANCE step; e events in WRITE/ADVANCE are dropped.
REQ-025 Address arithmetic SHALL be modulo DEPTH for non-power-of-two DEPTH; wadd never reaches DEPTH.

Reset
REQ-026 Reset SHALL force state INIT, wadd=0, din=0, w=0, nibble_idx=0, pending=0, synchroniser and edge-detect flops=0, taking priority over all events, including mid-write (w drops the next cycle).
REQ-027 No output SHALL depend on initial blocks; reset is the only initialisation.

Configuration
REQ-028 Macro NIBBLE_ENTRY_AUTO_INCR_EN: if defined, ADVANCE SHALL increment wadd with wrap; if undefined, ADVANCE leaves wadd unchanged, so repeated entries overwrite one address until a button moves it.

Structure
REQ-029 Package nibble_entry_pkg SHALL hold the state enum type and constant NIBBLE_W=4.
REQ-030 Sub-module nibble_entry_edge_sync (2-flop synchroniser + rising-edge pulse) SHALL be instantiated three times.

Verification
REQ-031 DATA_W=8, DEPTH=32, AUTO_INCR defined: e with data 4'hA then 4'h5 -> one w pulse with din=8'hA5, wadd=0; wadd=1 next COLLECT.
REQ-032 At wadd=31, enter 8'h3C -> w with wadd=31; wadd wraps to 0 afterwards. At wadd=0, decr -> wadd=31.
REQ-033 Enter nibble 4'h7, then incr -> nibble_idx=0, no w, wadd+1; next two nibbles 4'h1, 4'h2 -> din=8'h12.
REQ-034 incr and decr rising in same cycle -> wadd unchanged, pending stays 0; decr during WRITE -> pending=1, applied after ADVANCE (net wadd unchanged).
REQ-035 DEPTH=5, DATA_W=16, macro undefined: four nibbles 1,2,3,4 -> din=16'h1234, wadd stays 0; incr x5 from 0 -> wadd=0; reset asserted in WRITE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/nibble_entry_pkg.sv
// -----------------------------------------------------------------------------
// nibble_entry_pkg
// Shared types and constants for the nibble-entry controller.
//   NIBBLE_W      : width of one entered nibble (4 bits)
//   entryState_t  : controller state encoding (INIT, COLLECT, WRITE, ADVANCE)
// -----------------------------------------------------------------------------
package nibble_entry_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_WRITE    = 2'd2,
      ST_ADVANCE  = 2'd3
   } entryState_t;

endpackage

// File: rtl/nibble_entry_edge_sync.sv
// -----------------------------------------------------------------------------
// nibble_entry_edge_sync
// Brings an asynchronous push-button / strobe into the clk domain through a
// two-flop synchroniser and emits a registered one-cycle pulse on each rise.
// The pulse is high after the third rising clk edge following the input rise.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; clears every flop
//   sigIn  : asynchronous input
//   pulse  : one-cycle pulse per detected rising edge
// -----------------------------------------------------------------------------
module nibble_entry_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic sigIn,
   output logic pulse
);

   logic metaReg;
   logic syncReg;
   logic syncDlyReg;
   logic pulseReg;

   always_ff @(posedge clk) begin
      if (reset) begin
         metaReg    <= 1'b0;
         syncReg    <= 1'b0;
         syncDlyReg <= 1'b0;
         pulseReg   <= 1'b0;
      end else begin
         metaReg    <= sigIn;
         syncReg    <= metaReg;
         syncDlyReg <= syncReg;
         pulseReg   <= syncReg & ~syncDlyReg;
      end
   end

   assign pulse = pulseReg;

endmodule

// File: rtl/nibble_entry_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_entry_ctrl
// Assembles DATA_W-bit words from 4-bit nibbles typed in on a strobe, most
// significant nibble first, and writes each completed word to address wadd.
// Two buttons move the write address up/down with wrap modulo DEPTH.
// Build option: define NIBBLE_ENTRY_AUTO_INCR_EN to step wadd by +1 after
// every write; otherwise the address only moves on button presses.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   addr_incr  : async button, each rise requests address +1
//   addr_decr  : async button, each rise requests address -1
//   e          : async strobe, each rise captures data
//   data       : nibble value captured on an e event
//   wadd       : current write address
//   din        : assembled write word
//   w          : write-enable, high for one cycle per completed word
//   nibble_idx : nibbles already entered for the current word
//   pending    : a button request is waiting for the write to finish
// -----------------------------------------------------------------------------
module nibble_entry_ctrl
   import nibble_entry_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                addr_incr,
   input  logic                addr_decr,
   input  logic                e,
   input  logic [3:0]          data,
   output logic [ADDR_W-1:0]   wadd,
   output logic [DATA_W-1:0]   din,
   output logic                w,
   output logic [((DATA_W/NIBBLE_W > 1) ? $clog2(DATA_W/NIBBLE_W) : 1)-1:0] nibble_idx,
   output logic                pending
);

   localparam int NIBBLES = DATA_W / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

   entryState_t       stateReg, stateNext;
   logic [ADDR_W-1:0] waddReg, waddNext;
   logic [DATA_W-1:0] dinReg, dinNext;
   logic [DATA_W-1:0] dinLoaded;
   logic [IDX_W-1:0]  idxReg, idxNext;
   logic              pendingReg, pendingNext;
   logic              pendDirReg, pendDirNext;   // 1 = increment queued

   logic incEv;
   logic decEv;
   logic eEv;
   logic btnEv;
   genvar gi;

   // Address step with wrap; works for any DEPTH, not only powers of two.
   function automatic logic [ADDR_W-1:0] stepAddr(input logic [ADDR_W-1:0] a,
                                                   input logic up);
      if (up)
         return (a == ADDR_MAX) ? '0 : a + ADDR_W'(1);
      else
         return (a == '0) ? ADDR_MAX : a - ADDR_W'(1);
   endfunction

   nibble_entry_edge_sync uIncSync (.clk(clk), .reset(reset), .sigIn(addr_incr), .pulse(incEv));
   nibble_entry_edge_sync uDecSync (.clk(clk), .reset(reset), .sigIn(addr_decr), .pulse(decEv));
   nibble_entry_edge_sync uESync   (.clk(clk), .reset(reset), .sigIn(e),         .pulse(eEv));

   // Coincident up/down presses cancel each other entirely.
   assign btnEv = incEv ^ decEv;

   // Lane 0 is the most significant nibble; only the lane selected by the
   // current nibble index takes the new value.
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : gLane
         assign dinLoaded[DATA_W-NIBBLE_W*(gi+1) +: NIBBLE_W] =
            (idxReg == IDX_W'(gi)) ? data : dinReg[DATA_W-NIBBLE_W*(gi+1) +: NIBBLE_W];
      end
   endgenerate

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg   <= ST_INIT;
         waddReg    <= '0;
         dinReg     <= '0;
         idxReg     <= '0;
         pendingReg <= 1'b0;
         pendDirReg <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         waddReg    <= waddNext;
         dinReg     <= dinNext;
         idxReg     <= idxNext;
         pendingReg <= pendingNext;
         pendDirReg <= pendDirNext;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      stateNext   = stateReg;
      waddNext    = waddReg;
      dinNext     = dinReg;
      idxNext     = idxReg;
      pendingNext = pendingReg;
      pendDirNext = pendDirReg;
      case (stateReg)
         ST_INIT: begin
            waddNext    = '0;
            dinNext     = '0;
            idxNext     = '0;
            pendingNext = 1'b0;
            stateNext   = ST_COLLECT;
         end
         ST_COLLECT: begin
            // A fresh button beats a queued one (latest wins); any button
            // restarts the word and swallows a coincident e event.
            if (btnEv) begin
               waddNext    = stepAddr(waddReg, incEv);
               idxNext     = '0;
               pendingNext = 1'b0;
            end else if (pendingReg) begin
               waddNext    = stepAddr(waddReg, pendDirReg);
               idxNext     = '0;
               pendingNext = 1'b0;
            end else if (eEv) begin
               dinNext = dinLoaded;
               if (idxReg == LAST_IDX) begin
                  idxNext   = '0;
                  stateNext = ST_WRITE;
               end else begin
                  idxNext = idxReg + IDX_W'(1);
               end
            end
         end
         ST_WRITE: begin
            if (btnEv) begin
               pendingNext = 1'b1;
               pendDirNext = incEv;
            end
            stateNext = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            if (btnEv) begin
               pendingNext = 1'b1;
               pendDirNext = incEv;
            end
`ifdef NIBBLE_ENTRY_AUTO_INCR_EN
            waddNext = stepAddr(waddReg, 1'b1);
`else
            waddNext = waddReg;
`endif
            stateNext = ST_COLLECT;
         end
         default: stateNext = ST_INIT;
      endcase
   end

   // Outputs.
   always_comb begin
      w = 1'b0;
      if (stateReg == ST_WRITE)
         w = 1'b1;
   end

   assign wadd       = waddReg;
   assign din        = dinReg;
   assign nibble_idx = idxReg;
   assign pending    = pendingReg;

endmodule

// File: tb/tb_nibble_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_entry_ctrl
// Two controllers share one set of inputs: dut0 (DATA_W=8, DEPTH=32) and
// dut1 (DATA_W=16, DEPTH=5). Directed scenarios check fixed values; a random
// phase compares every cycle against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_nibble_entry_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       addr_incr = 1'b0;
   logic       addr_decr = 1'b0;
   logic       e = 1'b0;
   logic [3:0] data = 4'h0;

   logic [4:0]  wadd0;
   logic [7:0]  din0;
   logic        w0;
   logic [0:0]  idx0;
   logic        pending0;
   logic [2:0]  wadd1;
   logic [15:0] din1;
   logic        w1;
   logic [1:0]  idx1;
   logic        pending1;

   nibble_entry_ctrl #(.DATA_W(8), .DEPTH(32)) dut0 (
      .clk(clk), .reset(reset), .addr_incr(addr_incr), .addr_decr(addr_decr),
      .e(e), .data(data), .wadd(wadd0), .din(din0), .w(w0),
      .nibble_idx(idx0), .pending(pending0));

   nibble_entry_ctrl #(.DATA_W(16), .DEPTH(5)) dut1 (
      .clk(clk), .reset(reset), .addr_incr(addr_incr), .addr_decr(addr_decr),
      .e(e), .data(data), .wadd(wadd1), .din(din1), .w(w1),
      .nibble_idx(idx1), .pending(pending1));

`ifdef NIBBLE_ENTRY_AUTO_INCR_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   int compared = 0;
   int mismatched = 0;

   // Write-pulse recorder.
   int          wCnt0 = 0, wCnt1 = 0;
   logic [7:0]  lastDin0;
   logic [4:0]  lastWadd0;
   logic [15:0] lastDin1;
   logic [2:0]  lastWadd1;

   always @(negedge clk) begin
      if (w0 === 1'b1) begin wCnt0++; lastDin0 = din0; lastWadd0 = wadd0; end
      if (w1 === 1'b1) begin wCnt1++; lastDin1 = din1; lastWadd1 = wadd1; end
   end

   // Reference model: inputs seen through a 4-deep sample history; an event
   // reaches the controller when a sample 3 edges old is 1 and 4 edges old is 0.
   logic [3:0] hI = '0, hD = '0, hE = '0;
   int  mDepth[2] = '{32, 5};
   int  mNibs[2]  = '{2, 4};
   int  mWadd[2], mDin[2], mIdx[2], mBusy[2];
   bit  mPend[2], mPdir[2], mInit[2];

   always @(posedge clk) begin
      logic evI, evD, evE, btn, up;
      int sh;
      evI = hI[2] & ~hI[3];
      evD = hD[2] & ~hD[3];
      evE = hE[2] & ~hE[3];
      btn = evI ^ evD;
      if (reset) begin
         hI = '0; hD = '0; hE = '0;
      end else begin
         hI = {hI[2:0], addr_incr};
         hD = {hD[2:0], addr_decr};
         hE = {hE[2:0], e};
      end
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mInit[i] = 1; mBusy[i] = 0; mWadd[i] = 0; mDin[i] = 0;
            mIdx[i] = 0; mPend[i] = 0; mPdir[i] = 0;
         end else if (mInit[i]) begin
            mInit[i] = 0; mWadd[i] = 0; mDin[i] = 0; mIdx[i] = 0; mPend[i] = 0;
         end else if (mBusy[i] != 0) begin
            if (btn) begin mPend[i] = 1; mPdir[i] = evI; end
            if (mBusy[i] == 1 && AUTO) mWadd[i] = (mWadd[i] + 1) % mDepth[i];
            mBusy[i]--;
         end else if (btn || mPend[i]) begin
            up = btn ? evI : mPdir[i];
            mWadd[i] = up ? (mWadd[i] + 1) % mDepth[i]
                          : (mWadd[i] + mDepth[i] - 1) % mDepth[i];
            mIdx[i] = 0;
            mPend[i] = 0;
         end else if (evE) begin
            sh = 4 * (mNibs[i] - 1 - mIdx[i]);
            mDin[i] = (mDin[i] & ~(32'hF << sh)) | (int'(data) << sh);
            mIdx[i]++;
            if (mIdx[i] == mNibs[i]) begin mIdx[i] = 0; mBusy[i] = 2; end
         end
      end
   end

   // Stimulus helpers (all return on a falling edge with inputs low).
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(3); reset = 1'b0; tick(2);
   endtask

   task automatic enter_nibble(input logic [3:0] d);
      data = d; e = 1'b1; tick(2); e = 1'b0; tick(3);
   endtask

   task automatic press(input logic inc, input logic dec);
      addr_incr = inc; addr_decr = dec; tick(2);
      addr_incr = 1'b0; addr_decr = 1'b0; tick(3);
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(3);
      compared++;
      if ({w0, pending0, idx0, din0, wadd0} !== '0) begin
         mismatched++;
         $display("FAIL reset_dut0: got %h required 0", {w0, pending0, idx0, din0, wadd0});
      end
      compared++;
      if ({w1, pending1, idx1, din1, wadd1} !== '0) begin
         mismatched++;
         $display("FAIL reset_dut1: got %h required 0", {w1, pending1, idx1, din1, wadd1});
      end
      reset = 1'b0; tick(2);
      compared++;
      if ({w0, pending0, idx0, din0, wadd0} !== '0) begin
         mismatched++;
         $display("FAIL init_dut0: got %h required 0", {w0, pending0, idx0, din0, wadd0});
      end
      $display("test_reset done");
   endtask

   task automatic test_basic_write();
      int c0;
      do_reset();
      c0 = wCnt0;
      enter_nibble(4'hA);
      compared++;
      if (idx0 !== 1'b1 || din0 !== 8'hA0) begin
         mismatched++;
         $display("FAIL first_nibble: got idx=%0d din=%h required idx=1 din=a0", idx0, din0);
      end
      enter_nibble(4'h5);
      tick(2);
      compared++;
      if (wCnt0 - c0 !== 1 || lastDin0 !== 8'hA5 || lastWadd0 !== 5'd0) begin
         mismatched++;
         $display("FAIL write_a5: got pulses=%0d din=%h wadd=%0d required pulses=1 din=a5 wadd=0",
                  wCnt0 - c0, lastDin0, lastWadd0);
      end
      compared++;
      if (wadd0 !== 5'(AUTO)) begin
         mismatched++;
         $display("FAIL post_write_addr: got %0d required %0d", wadd0, AUTO);
      end
      compared++;
      if (idx1 !== 2'd2 || din1 !== 16'hA500) begin
         mismatched++;
         $display("FAIL wide_partial: got idx=%0d din=%h required idx=2 din=a500", idx1, din1);
      end
      $display("test_basic_write done");
   endtask

   task automatic test_wrap();
      do_reset();
      press(1'b0, 1'b1);
      compared++;
      if (wadd0 !== 5'd31 || wadd1 !== 3'd4) begin
         mismatched++;
         $display("FAIL decr_wrap: got %0d/%0d required 31/4", wadd0, wadd1);
      end
      press(1'b1, 1'b0);
      compared++;
      if (wadd0 !== 5'd0 || wadd1 !== 3'd0) begin
         mismatched++;
         $display("FAIL incr_wrap: got %0d/%0d required 0/0", wadd0, wadd1);
      end
      press(1'b0, 1'b1);
      enter_nibble(4'h3);
      enter_nibble(4'hC);
      tick(2);
      compared++;
      if (lastWadd0 !== 5'd31 || lastDin0 !== 8'h3C) begin
         mismatched++;
         $display("FAIL write_top: got wadd=%0d din=%h required wadd=31 din=3c", lastWadd0, lastDin0);
      end
      compared++;
      if (wadd0 !== (AUTO ? 5'd0 : 5'd31)) begin
         mismatched++;
         $display("FAIL top_advance: got %0d required %0d", wadd0, AUTO ? 0 : 31);
      end
      press(1'b0, 1'b1);
      compared++;
      if (wadd0 !== (AUTO ? 5'd31 : 5'd30)) begin
         mismatched++;
         $display("FAIL decr_after_write: got %0d required %0d", wadd0, AUTO ? 31 : 30);
      end
      $display("test_wrap done");
   endtask

   task automatic test_discard();
      int c0;
      do_reset();
      c0 = wCnt0;
      enter_nibble(4'h7);
      compared++;
      if (idx0 !== 1'b1) begin
         mismatched++;
         $display("FAIL partial_idx: got %0d required 1", idx0);
      end
      press(1'b1, 1'b0);
      compared++;
      if (idx0 !== 1'b0 || wadd0 !== 5'd1 || wCnt0 !== c0) begin
         mismatched++;
         $display("FAIL discard: got idx=%0d wadd=%0d pulses=%0d required idx=0 wadd=1 pulses=0",
                  idx0, wadd0, wCnt0 - c0);
      end
      enter_nibble(4'h1);
      enter_nibble(4'h2);
      tick(2);
      compared++;
      if (wCnt0 - c0 !== 1 || lastDin0 !== 8'h12 || lastWadd0 !== 5'd1) begin
         mismatched++;
         $display("FAIL write_12: got pulses=%0d din=%h wadd=%0d required pulses=1 din=12 wadd=1",
                  wCnt0 - c0, lastDin0, lastWadd0);
      end
      $display("test_discard done");
   endtask

   task automatic test_cancel_and_queue();
      do_reset();
      press(1'b1, 1'b1);
      compared++;
      if (wadd0 !== 5'd0 || pending0 !== 1'b0 || wadd1 !== 3'd0 || pending1 !== 1'b0) begin
         mismatched++;
         $display("FAIL cancel: got wadd=%0d/%0d pending=%b/%b required 0/0 0/0",
                  wadd0, wadd1, pending0, pending1);
      end
      enter_nibble(4'hA);
      // Final nibble, then a decrement timed to land in the write cycle.
      data = 4'h5; e = 1'b1; tick(1);
      addr_decr = 1'b1; tick(1);
      e = 1'b0; tick(1);
      addr_decr = 1'b0; tick(1);
      compared++;
      if (w0 !== 1'b1) begin
         mismatched++;
         $display("FAIL write_cycle: got w=%b required 1", w0);
      end
      tick(1);
      compared++;
      if (pending0 !== 1'b1) begin
         mismatched++;
         $display("FAIL queued: got pending=%b required 1", pending0);
      end
      tick(2);
      compared++;
      if (pending0 !== 1'b0 || wadd0 !== (AUTO ? 5'd0 : 5'd31)) begin
         mismatched++;
         $display("FAIL queue_applied: got pending=%b wadd=%0d required 0 %0d",
                  pending0, wadd0, AUTO ? 0 : 31);
      end
      compared++;
      if (wadd1 !== 3'd4 || pending1 !== 1'b0) begin
         mismatched++;
         $display("FAIL direct_decr: got wadd=%0d pending=%b required 4 0", wadd1, pending1);
      end
      $display("test_cancel_and_queue done");
   endtask

   task automatic test_depth5();
      int c0, c1;
      do_reset();
      repeat (5) press(1'b1, 1'b0);
      compared++;
      if (wadd1 !== 3'd0 || wadd0 !== 5'd5) begin
         mismatched++;
         $display("FAIL incr_x5: got %0d/%0d required 5/0", wadd0, wadd1);
      end
      do_reset();
      c0 = wCnt0; c1 = wCnt1;
      enter_nibble(4'h1); enter_nibble(4'h2); enter_nibble(4'h3); enter_nibble(4'h4);
      tick(2);
      compared++;
      if (wCnt1 - c1 !== 1 || lastDin1 !== 16'h1234 || lastWadd1 !== 3'd0) begin
         mismatched++;
         $display("FAIL wide_write: got pulses=%0d din=%h wadd=%0d required 1 1234 0",
                  wCnt1 - c1, lastDin1, lastWadd1);
      end
      compared++;
      if (wadd1 !== 3'(AUTO) || wCnt0 - c0 !== 2 || lastDin0 !== 8'h34) begin
         mismatched++;
         $display("FAIL after_wide: got wadd1=%0d pulses0=%0d din0=%h required %0d 2 34",
                  wadd1, wCnt0 - c0, lastDin0, AUTO);
      end
      do_reset();
      enter_nibble(4'h1);
      data = 4'h2; e = 1'b1; tick(2); e = 1'b0; tick(2);
      compared++;
      if (w0 !== 1'b1) begin
         mismatched++;
         $display("FAIL pre_reset_write: got w=%b required 1", w0);
      end
      reset = 1'b1; tick(1);
      compared++;
      if ({w0, pending0, idx0, din0, wadd0} !== '0 || {w1, pending1, idx1, din1, wadd1} !== '0) begin
         mismatched++;
         $display("FAIL reset_in_write: got %h %h required 0 0",
                  {w0, pending0, idx0, din0, wadd0}, {w1, pending1, idx1, din1, wadd1});
      end
      reset = 1'b0; tick(2);
      $display("test_depth5 done");
   endtask

   task automatic test_random();
      logic [15:0] exp0, got0;
      logic [24:0] exp1, got1;
      do_reset();
      for (int n = 0; n < 2500; n++) begin
         exp0 = {mBusy[0] == 2, mPend[0], mIdx[0][0:0], mDin[0][7:0], mWadd[0][4:0]};
         got0 = {w0, pending0, idx0, din0, wadd0};
         compared++;
         if (got0 !== exp0) begin
            mismatched++;
            $display("FAIL random_dut0 cycle %0d: got %h required %h", n, got0, exp0);
         end
         exp1 = {mBusy[1] == 2, mPend[1], mIdx[1][1:0], mDin[1][15:0], mWadd[1][2:0]};
         got1 = {w1, pending1, idx1, din1, wadd1};
         compared++;
         if (got1 !== exp1) begin
            mismatched++;
            $display("FAIL random_dut1 cycle %0d: got %h required %h", n, got1, exp1);
         end
         if ($urandom_range(0, 5) == 0) addr_incr = ~addr_incr;
         if ($urandom_range(0, 5) == 0) addr_decr = ~addr_decr;
         if ($urandom_range(0, 2) == 0) e = ~e;
         data  = 4'($urandom);
         reset = ($urandom_range(0, 399) == 0);
         tick(1);
      end
      addr_incr = 1'b0; addr_decr = 1'b0; e = 1'b0; reset = 1'b0;
      tick(6);
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_wrap();
      test_discard();
      test_cancel_and_queue();
      test_depth5();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
